// File: rtl/divide_constant_17_sequential_pkg.sv
// divide_constant_17_sequential_pkg: shared widths, divisor and FSM state encoding
package divide_constant_17_sequential_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int DIVISOR = 17;
  localparam int REM_WIDTH = 5;
  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/divide_constant_17_sequential_if.sv
// divide_constant_17_sequential_if: start/dividend request and busy/done/quotient/remainder result bundle
// Ports: master drives start/dividend; slave (divider) drives busy/done/quotient/remainder.
interface divide_constant_17_sequential_if import divide_constant_17_sequential_pkg::*; ();
  logic start;
  logic [DATA_WIDTH-1:0] dividend;
  logic busy;
  logic done;
  logic [DATA_WIDTH-1:0] quotient;
  logic [REM_WIDTH-1:0] remainder;
  modport master(output start, dividend, input busy, done, quotient, remainder);
  modport slave(input start, dividend, output busy, done, quotient, remainder);
endinterface

// File: rtl/divide_constant_17_sequential_div_const_step.sv
// divide_constant_17_sequential_div_const_step: one restoring-division step against the constant divisor
// Ports: i_r partial remainder, i_bit next dividend bit; o_r new remainder, o_q quotient bit.
module divide_constant_17_sequential_div_const_step import divide_constant_17_sequential_pkg::*; (
  input  logic [REM_WIDTH-1:0] i_r,
  input  logic                 i_bit,
  output logic [REM_WIDTH-1:0] o_r,
  output logic                 o_q
);
  logic [REM_WIDTH:0] w_t;
  always_comb begin
    w_t = {i_r, i_bit};
    o_q = w_t >= (REM_WIDTH+1)'(DIVISOR);
    o_r = o_q ? REM_WIDTH'(w_t - (REM_WIDTH+1)'(DIVISOR)) : w_t[REM_WIDTH-1:0];
  end
endmodule

// File: rtl/divide_constant_17_sequential.sv
// divide_constant_17_sequential: iterative MSB-first restoring divider by a constant, one bit per clock
// Ports: clk, rst (async, active-high); bus.slave carries start/dividend in, busy/done/quotient/remainder out.
module divide_constant_17_sequential import divide_constant_17_sequential_pkg::*; (
  input logic clk,
  input logic rst,
  divide_constant_17_sequential_if.slave bus
);
  state_t r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [REM_WIDTH-1:0] r_rem;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic r_busy;
  logic r_done;
  logic [DATA_WIDTH-1:0] r_quot;
  logic [REM_WIDTH-1:0] r_rem_out;
  logic [REM_WIDTH-1:0] w_r;
  logic w_q;
  logic [DATA_WIDTH-1:0] w_shift_next;
  divide_constant_17_sequential_div_const_step u_step (
    .i_r  (r_rem),
    .i_bit(r_shift[DATA_WIDTH-1]),
    .o_r  (w_r),
    .o_q  (w_q)
  );
  // dividend bits leave at the top while quotient bits enter at the bottom
  assign w_shift_next = {r_shift[DATA_WIDTH-2:0], w_q};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        CALC: begin
          r_shift <= w_shift_next;
          r_rem   <= w_r;
          if (r_cnt == CNT_WIDTH'(DATA_WIDTH-1)) begin
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_quot    <= w_shift_next;
            r_rem_out <= w_r;
          end else r_cnt <= r_cnt + 1'b1;
        end
        IDLE, DONE: begin
          if (bus.start) begin
            r_state <= CALC;
            r_shift <= bus.dividend;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end else r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_rem_out;
endmodule

// File: tb/tb_divide_constant_17_sequential.sv
// tb_divide_constant_17_sequential: directed and random checks of the divide-by-17 unit against plain arithmetic
module tb_divide_constant_17_sequential;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  divide_constant_17_sequential_if bus ();
  divide_constant_17_sequential dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_quot"}, int'(bus.quotient), 0);
    chk({tag, "_rem"}, int'(bus.remainder), 0);
  endtask
  // Launches one division and follows it to its done cycle; returns in the done cycle.
  // Edges are counted with the accepting edge as edge 1, so done must appear after edge 17.
  task automatic op(input int d, input bit noise);
    int edges;
    int busy_cyc;
    bit seen;
    bus.start = 1'b1;
    bus.dividend = 16'(d);
    tick();
    edges = 1;
    busy_cyc = 0;
    seen = 1'b0;
    bus.start = 1'b0;
    while (!seen && edges < 40) begin
      if (bus.busy) busy_cyc++;
      if (bus.busy && bus.done) chk("busy_done_overlap", 1, 0);
      if (noise && edges < 15) begin
        bus.start = 1'($urandom);
        bus.dividend = 16'($urandom);
      end else bus.start = 1'b0;
      tick();
      edges++;
      seen = bus.done;
    end
    chk("done_seen", int'(seen), 1);
    chk("latency", edges, 17);
    chk("busy_cycles", busy_cyc, 16);
    chk("done_busy_low", int'(bus.busy), 0);
    chk($sformatf("quot_%0d", d), int'(bus.quotient), d / 17);
    chk($sformatf("rem_%0d", d), int'(bus.remainder), d % 17);
  endtask
  // After an operation, the pulse must end and the result must hold through IDLE.
  task automatic hold(input int d, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk("hold_done_low", int'(bus.done), 0);
      chk("hold_busy_low", int'(bus.busy), 0);
      chk("hold_quot", int'(bus.quotient), d / 17);
      chk("hold_rem", int'(bus.remainder), d % 17);
    end
  endtask
  initial begin
    int d;
    bus.start = 1'b0;
    bus.dividend = '0;
    tick();
    tick();
    check_idle_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle_zero("idle");
    end
    op(4335, 1'b0);
    hold(4335, 2);
    op(65535, 1'b0);
    hold(65535, 1);
    op(0, 1'b0);
    hold(0, 1);
    op(16, 1'b0);
    hold(16, 1);
    op(1000, 1'b0);
    op(17, 1'b0);
    hold(17, 2);
    op(2024, 1'b1);
    hold(2024, 3);
    for (int i = 0; i < 8; i++) begin
      d = (i % 2 == 0) ? int'($urandom_range(65535)) : int'($urandom_range(3855)) * 17;
      op(d, i > 5);
      hold(d, 1);
    end
    bus.start = 1'b1;
    bus.dividend = 16'd4335;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("mid_calc_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check_idle_zero("async_rst");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_rst_no_done", int'(bus.done), 0);
    end
    op(34, 1'b0);
    hold(34, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
